// File: rtl/irrigation_controller.sv
// Irrigation sequencing controller: picks the outlet (sprinkler or drip),
// times the run, enforces a cooldown after every run and a tank-empty lockout.
// All outputs are registered from the next state, so they change on the same
// edge as the state they describe.
module irrigation_controller #(
    parameter int unsigned RUN_TICKS  = 8,
    parameter int unsigned COOL_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [1:0] humidity,
    input  logic       tank_low,
    input  logic       auto_en,
    input  logic       manual_start,
    input  logic       manual_sel,
    input  logic       manual_stop,
    output logic       sprinkler_en,
    output logic       drip_en,
    output logic [1:0] mode,
    output logic       alarm,
    output logic       busy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN_SPR  = 3'd1,
        S_RUN_DRIP = 3'd2,
        S_COOL     = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    localparam logic [7:0] RUN_LIM  = RUN_TICKS[7:0];
    localparam logic [7:0] COOL_LIM = COOL_TICKS[7:0];

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       manual_q, manual_d;
    logic [7:0] cnt_inc;
    logic       run_abort;
    logic       spr_d, drip_d, alarm_d, busy_d;
    logic [1:0] mode_d;

    // Saturating increment: the counter parks at 255 instead of wrapping.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Auto runs stop on wet soil or leaving auto mode; manual runs stop on
    // manual_stop or entering auto mode. Run type is fixed at entry, so the
    // level of auto_en is enough to detect the abort edge.
    assign run_abort = manual_q ? (manual_stop || auto_en)
                                : ((humidity == 2'b00) || !auto_en);

    assign dbg_state = state_q;

    // Next-state and next-output logic; tank_low outranks every other exit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        manual_d = manual_q;
        if (tick) cnt_d = cnt_inc;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (tank_low) begin
                    state_d = S_ALARM;
                end else if (auto_en) begin
                    manual_d = 1'b0;
                    if (humidity == 2'b11)      state_d = S_RUN_SPR;
                    else if (humidity == 2'b10) state_d = S_RUN_DRIP;
                end else if (manual_start && !manual_stop) begin
                    manual_d = 1'b1;
                    state_d  = manual_sel ? S_RUN_SPR : S_RUN_DRIP;
                end
            end
            S_RUN_SPR, S_RUN_DRIP: begin
                if (tank_low) begin
                    state_d = S_ALARM;
                    cnt_d   = 8'd0;
                end else if ((tick && cnt_inc >= RUN_LIM) || run_abort) begin
                    state_d = S_COOL;
                    cnt_d   = 8'd0;
                end
            end
            S_COOL: begin
                if (tank_low) begin
                    state_d = S_ALARM;
                    cnt_d   = 8'd0;
                end else if (tick && cnt_inc >= COOL_LIM) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            S_ALARM: begin
                cnt_d = 8'd0;
                if (!tank_low) state_d = S_COOL;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        spr_d   = (state_d == S_RUN_SPR);
        drip_d  = (state_d == S_RUN_DRIP);
        alarm_d = (state_d == S_ALARM);
        busy_d  = (state_d != S_IDLE);
        if (spr_d)       mode_d = 2'b01;
        else if (drip_d) mode_d = 2'b10;
        else             mode_d = auto_en ? 2'b00 : 2'b11;
    end

    // State, counter and registered outputs; reset closes valves immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            manual_q     <= 1'b0;
            sprinkler_en <= 1'b0;
            drip_en      <= 1'b0;
            mode         <= 2'b00;
            alarm        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            manual_q     <= manual_d;
            sprinkler_en <= spr_d;
            drip_en      <= drip_d;
            mode         <= mode_d;
            alarm        <= alarm_d;
            busy         <= busy_d;
        end
    end

endmodule
